// File: rtl/morse_keyer.sv
// Morse output stage: accepts one character per GPIO request toggle and plays it
// on the key pin with standard unit timing; counts completed characters.
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 120
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] GPIO,
  output logic        key,
  output logic        busy,
  output logic        ack_tog,
  output logic [7:0]  char_cnt
);

  localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cyc;
  logic [2:0]    units;
  logic [2:0]    idx;
  logic [2:0]    len;
  logic [4:0]    pat;
  logic [2:0]    cnt_dec;
  logic          pending;
  logic          unit_end;
  logic          phase_end;

  always_comb begin
    pending    = (GPIO[31] != ack_tog);
    cnt_dec    = (GPIO[7:5] > 3'd5) ? 3'd5 : GPIO[7:5];
    unit_end   = (cyc == CYC_LAST);

    // Phase length in units; a MARK's length comes from the element being sent.
    len = 3'd1;
    case (state)
      MARK:     len = pat[idx] ? 3'd3 : 3'd1;
      CHAR_GAP: len = 3'd3;
      WORD_GAP: len = 3'd7;
      default:  len = 3'd1;
    endcase
    phase_end = unit_end && (units == len - 3'd1);

    state_next = state;
    case (state)
      IDLE: begin
        if (pending) begin
          if (GPIO[8])
            state_next = WORD_GAP;
          else if (cnt_dec != 3'd0)
            state_next = MARK;
        end
      end
      MARK:     if (phase_end) state_next = (idx == 3'd0) ? CHAR_GAP : ELEM_GAP;
      ELEM_GAP: if (phase_end) state_next = MARK;
      CHAR_GAP: if (phase_end) state_next = IDLE;
      WORD_GAP: if (phase_end) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cyc      <= '0;
      units    <= '0;
      idx      <= '0;
      pat      <= '0;
      ack_tog  <= 1'b0;
      char_cnt <= '0;
    end else if (state == IDLE) begin
      cyc   <= '0;
      units <= '0;
      if (pending) begin
        ack_tog <= GPIO[31];
        pat     <= GPIO[4:0];
        idx     <= cnt_dec - 3'd1;
      end
    end else if (phase_end) begin
      cyc   <= '0;
      units <= '0;
      if (state == ELEM_GAP)
        idx <= idx - 3'd1;
      if (state == CHAR_GAP)
        char_cnt <= char_cnt + 8'd1;
    end else if (unit_end) begin
      cyc   <= '0;
      units <= units + 3'd1;
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

  assign key  = (state == MARK);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer at UNIT_CYCLES=4: table of characters plus
// hand sequences for back-to-back requests, reset mid-dash and counter wrap.
module tb_morse_keyer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] GPIO;
  logic        key;
  logic        busy;
  logic        ack_tog;
  logic [7:0]  char_cnt;

  int tests = 0;
  int failures = 0;

  morse_keyer #(.UNIT_CYCLES(4)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .GPIO     (GPIO),
    .key      (key),
    .busy     (busy),
    .ack_tog  (ack_tog),
    .char_cnt (char_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] gpio;
    int          key_cyc;
    int          busy_cyc;
    int          cnt;
    logic        ack;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    GPIO  = '0;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    int          kc;
    int          bc;
    logic [63:0] kv;
    logic [63:0] bv;
    logic [63:0] kexp;
    logic [63:0] bexp;

    vecs[0]  = '{32'h8000_0041, 16, 32, 1, 1'b1};  // A: dot dash
    vecs[1]  = '{32'h0000_0100,  0, 28, 1, 1'b0};  // word gap
    vecs[2]  = '{32'h8000_0000,  0,  0, 1, 1'b1};  // null
    vecs[3]  = '{32'h0000_00FF, 60, 88, 2, 1'b0};  // count 7 -> 5 dashes
    vecs[4]  = '{32'h8000_0020,  4, 16, 3, 1'b1};  // E
    vecs[5]  = '{32'h0000_00A0, 20, 48, 4, 1'b0};  // five dots
    vecs[6]  = '{32'h8000_00D5, 44, 72, 5, 1'b1};  // count 6 -> 5: dash dot dash dot dash
    vecs[7]  = '{32'h0000_0066, 28, 48, 6, 1'b0};  // dash dash dot
    vecs[8]  = '{32'h8000_01FF,  0, 28, 6, 1'b1};  // word gap overrides fields
    vecs[9]  = '{32'h0000_0000,  0,  0, 6, 1'b0};  // null, toggle 0
    vecs[10] = '{32'h0000_0041,  0,  0, 6, 1'b0};  // toggle equals ack: not pending
    vecs[11] = '{32'h8000_0089, 32, 56, 7, 1'b1};  // dash dot dot dash
    vecs[12] = '{32'h0000_0020,  4, 16, 8, 1'b0};  // E

    Reset = 1'b1;
    GPIO  = '0;
    step();
    step();
    check("reset_key", int'(key), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ack", int'(ack_tog), 0);
    check("reset_cnt", int'(char_cnt), 0);
    Reset = 1'b0;

    // A with E queued during A's dash; E's data must not disturb A.
    GPIO = 32'h8000_0041;
    kv = '0;
    bv = '0;
    for (int s = 0; s < 60; s++) begin
      step();
      kv[s] = key;
      bv[s] = busy;
      if (s == 10) GPIO = 32'h0000_0020;
    end
    kexp = '0;
    bexp = '0;
    for (int s = 0; s < 60; s++) begin
      if (s <= 3 || (s >= 8 && s <= 19) || (s >= 33 && s <= 36)) kexp[s] = 1'b1;
      if (s <= 31 || (s >= 33 && s <= 48)) bexp[s] = 1'b1;
    end
    check_vec("a_then_e_key", kv, kexp);
    check_vec("a_then_e_busy", bv, bexp);
    check("a_then_e_cnt", int'(char_cnt), 2);
    check("a_then_e_ack", int'(ack_tog), 0);

    do_reset();

    foreach (vecs[i]) begin
      GPIO = vecs[i].gpio;
      kc = 0;
      bc = 0;
      for (int s = 0; s < 100; s++) begin
        step();
        if (key === 1'b1) kc++;
        if (busy === 1'b1) bc++;
      end
      check($sformatf("vec%0d_key_cycles", i), kc, vecs[i].key_cyc);
      check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].busy_cyc);
      check($sformatf("vec%0d_char_cnt", i), int'(char_cnt), vecs[i].cnt);
      check($sformatf("vec%0d_ack", i), int'(ack_tog), int'(vecs[i].ack));
    end

    // Null request acknowledges on the first edge without raising busy.
    GPIO = 32'h8000_0000;
    step();
    check("null_ack_latency", int'(ack_tog), 1);
    check("null_busy", int'(busy), 0);
    GPIO = 32'h0000_0000;
    step();

    // Reset during a dash, request still asserted across the reset.
    GPIO = 32'h8000_0021;
    for (int s = 0; s < 5; s++) step();
    check("pre_reset_key", int'(key), 1);
    Reset = 1'b1;
    step();
    check("midreset_key", int'(key), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_cnt", int'(char_cnt), 0);
    check("midreset_ack", int'(ack_tog), 0);
    Reset = 1'b0;
    step();
    check("reaccept_key", int'(key), 1);
    check("reaccept_busy", int'(busy), 1);
    check("reaccept_ack", int'(ack_tog), 1);
    for (int s = 0; s < 30; s++) step();
    check("reaccept_done_busy", int'(busy), 0);
    check("reaccept_done_cnt", int'(char_cnt), 1);

    // 256 dots wrap the character counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      GPIO = (i % 2 == 0) ? 32'h8000_0020 : 32'h0000_0020;
      for (int s = 0; s < 20; s++) step();
      if (i == 254) check("wrap_cnt_255", int'(char_cnt), 255);
    end
    check("wrap_cnt_0", int'(char_cnt), 0);
    check("wrap_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
